shift_cmd_fifo: RTL and testbench

Command buffer that sits directly upstream of the 8-bit logical-right barrel shifter. It accepts {data, shift amount} commands over a valid/ready handshake and stores up to DEPTH of them in order. It presents the oldest command, first-word-fall-through, on ports that connect straight to the shifter's `data` and `shifter` inputs. This decouples a bursty producer from the purely combinational shift stage.

---
 rtl/shift_cmd_fifo.sv | 74 +++++++
 tb/tb_shift_cmd_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_fifo.sv
// Command FIFO feeding the logical-right barrel shifter: stores {data, shift}
// pairs and presents the oldest one first-word-fall-through.
module shift_cmd_fifo #(
    parameter int N     = 8,
    parameter int SW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    input  logic [SW-1:0]            in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [SW-1:0]            out_shift,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N+SW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [N+SW-1:0] head;
    logic            push;
    logic            pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // Ready depends on occupancy only, so a pop never frees a slot in the same cycle.
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign head      = mem[rd_ptr];
    assign out_data  = empty ? '0 : head[N+SW-1:SW];
    assign out_shift = empty ? '0 : head[SW-1:0];

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {in_data, in_shift};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Directed bench for shift_cmd_fifo: reset, fill/drain, full+pop, streaming
// wrap, flush and empty-side corner cases.
module tb_shift_cmd_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_data [$];
    logic [2:0] q_shift [$];

    logic [7:0] fd_data  [4] = '{8'd16, 8'd128, 8'd255, 8'd32};
    logic [2:0] fd_shift [4] = '{3'd4, 3'd2, 3'd1, 3'd7};
    logic [7:0] fd_res   [4] = '{8'd1, 8'd32, 8'd127, 8'd0};
    logic [7:0] fp_data  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
    logic [2:0] fp_shift [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

    shift_cmd_fifo #(.N(8), .SW(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_shift = 3'd1;
        out_ready = 1'b0;

        // Reset held two cycles with a command offered
        step();
        step();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check("rst_nothing_stored", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);

        // Fill and drain
        for (int i = 0; i < 4; i++) push(fd_data[i], fd_shift[i]);
        check("fill_full", 32'(full), 1);
        check("fill_in_ready", 32'(in_ready), 0);
        check("fill_count", 32'(count), 4);
        push(8'hAA, 3'd3);
        check("fifth_refused_count", 32'(count), 4);
        check("fifth_head_kept", 32'(out_data), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(out_data), 32'(fd_data[i]));
            check("drain_shift", 32'(out_shift), 32'(fd_shift[i]));
            check("drain_shifted", 32'(out_data >> out_shift), 32'(fd_res[i]));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 1);
        check("drain_out_data_zero", 32'(out_data), 0);
        check("drain_out_shift_zero", 32'(out_shift), 0);

        // Full with simultaneous pop: only the pop happens
        for (int i = 0; i < 4; i++) push(fp_data[i], fp_shift[i]);
        check("fp_count_full", 32'(count), 4);
        in_valid = 1'b1; in_data = fp_data[4]; in_shift = fp_shift[4]; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("fp_count_after_pop", 32'(count), 3);
        check("fp_head", 32'(out_data), 32'h22);
        check("fp_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("fp_retry_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("fp_drain_data", 32'(out_data), 32'(fp_data[i]));
            check("fp_drain_shift", 32'(out_shift), 32'(fp_shift[i]));
            step();
        end
        out_ready = 1'b0;
        check("fp_empty", 32'(empty), 1);

        // Streaming at count 2 with pointer wrap
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            logic [2:0] s;
            d = 8'($urandom);
            s = 3'($urandom);
            q_data.push_back(d);
            q_shift.push_back(s);
            push(d, s);
        end
        check("stream_count_init", 32'(count), 2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'($urandom);
            in_shift = 3'($urandom);
            check("stream_data", 32'(out_data), 32'(q_data[0]));
            check("stream_shift", 32'(out_shift), 32'(q_shift[0]));
            void'(q_data.pop_front());
            void'(q_shift.pop_front());
            q_data.push_back(in_data);
            q_shift.push_back(in_shift);
            step();
            check("stream_count", 32'(count), 2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stream_tail_data", 32'(out_data), 32'(q_data[0]));
            check("stream_tail_shift", 32'(out_shift), 32'(q_shift[0]));
            void'(q_data.pop_front());
            void'(q_shift.pop_front());
            step();
        end
        out_ready = 1'b0;
        check("stream_empty", 32'(empty), 1);

        // Flush with a concurrent push
        push(8'hA1, 3'd1);
        push(8'hB2, 3'd2);
        push(8'hC3, 3'd3);
        check("flush_pre_count", 32'(count), 3);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_shift = 3'd6;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        check("flush_out_data", 32'(out_data), 0);
        step();
        check("flush_push_absent", 32'(count), 0);

        // Empty edge cases
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_count", 32'(count), 0);
        check("empty_pop_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'd200; in_shift = 3'd0;
        #1;
        check("single_pre_valid", 32'(out_valid), 0);
        step();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 1);
        check("single_out_data", 32'(out_data), 200);
        check("single_out_shift", 32'(out_shift), 0);

        // Reset mid-burst drops pending entries
        push(8'h0F, 3'd2);
        check("burst_count", 32'(count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_count", 32'(count), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_data", 32'(out_data), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
